mmc_cmd_phy: RTL and testbench

- Parametrised successor to the MMC pad infrastructure: a command-line PHY for the MMC/SD interface.
- Generates the card clock through a programmable divider.
- Serialises 48-bit command frames with CRC7 and drives the command pad's output enable.
- Captures 48- or 136-bit responses with start-bit search, CRC7 and end-bit checking, and timeout detection.
- Tracks DAT0 busy for R1b responses.
- Sits between the pad buffers and the controller/register logic.

---
 rtl/mmc_cmd_phy.sv | 210 +++++++++++++++++++++
 tb/tb_mmc_cmd_phy.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmc_cmd_phy.sv
// mmc_cmd_phy: command-line PHY for an MMC/SD host.
//   - divides clk down to the card clock (mmc_clk) and produces rise/fall strobes
//   - serialises 48-bit command frames (start, transmit, index, arg, CRC7, end)
//     onto the command pad, driving cmd_out/cmd_oe only on mmc_clk falling edges
//   - searches for a response start bit, captures a 48- or 136-bit response,
//     checks CRC7 and end bit, flags a timeout if no start bit arrives
//   - tracks DAT0 busy after R1b responses
// Ports:
//   clk, reset           system clock, async active-high reset
//   clk_div              divider: mmc_clk half-period = clk_div+1 clk cycles
//   cmd_valid/cmd_ready  command handshake (ready only in IDLE)
//   cmd_index, cmd_arg   command fields
//   resp_type            00 none, 01 short, 10 long, 11 short+busy
//   resp_nocrc           ignore the CRC of the response (R3)
//   resp_valid           one-clk completion pulse with resp_data/resp_crc_err/resp_timeout
//   busy                 DAT0 held low by the card after an R1b response
//   mmc_clk, cmd_out, cmd_oe, cmd_in, dat0_in   pad side
module mmc_cmd_phy #(
    parameter int DIV_W   = 8,
    parameter int NCR_MAX = 64,
    parameter int NCC_MIN = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [5:0]       cmd_index,
    input  logic [31:0]      cmd_arg,
    input  logic [1:0]       resp_type,
    input  logic             resp_nocrc,
    output logic             resp_valid,
    output logic [127:0]     resp_data,
    output logic             resp_crc_err,
    output logic             resp_timeout,
    output logic             busy,
    output logic             mmc_clk,
    output logic             cmd_out,
    output logic             cmd_oe,
    input  logic             cmd_in,
    input  logic             dat0_in
);

    localparam int CNT_MAX0 = (NCR_MAX > 136) ? NCR_MAX : 136;
    localparam int CNT_MAX  = (NCC_MIN > CNT_MAX0) ? NCC_MIN : CNT_MAX0;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_TX, S_NCC, S_WAIT, S_RX, S_BUSY, S_DONE
    } state_t;

    state_t state, state_nx;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    // ---------------- card clock divider ----------------
    logic [DIV_W-1:0] div_cnt, div_lim, lim;
    logic             div_run, tc, rise_stb, fall_stb;

    // Until the first reload there is no captured limit yet, so the very first
    // half-period uses clk_div directly.
    assign lim      = div_run ? div_lim : clk_div;
    assign tc       = (div_cnt == lim);
    assign rise_stb = tc & ~mmc_clk;
    assign fall_stb = tc & mmc_clk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            div_lim <= '0;
            div_run <= 1'b0;
            mmc_clk <= 1'b0;
        end else if (tc) begin
            div_cnt <= '0;
            div_lim <= clk_div;
            div_run <= 1'b1;
            mmc_clk <= ~mmc_clk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // ---------------- control ----------------
    logic [CNT_W-1:0] cnt, n_bit, rx_len;
    logic [47:0]      tx_sr;
    logic [126:0]     rx_sr;
    logic [127:0]     rx_nx;
    logic [6:0]       rx_crc;
    logic [1:0]       rt_q;
    logic             nocrc_q, rdy_en, is_long, crc_en;
    logic             accept, tx_end, ncc_end, wait_start, wait_to, rx_last, busy_end;

    assign cmd_ready  = (state == S_IDLE) & rdy_en;
    assign resp_valid = (state == S_DONE);
    assign busy       = (state == S_BUSY) & ~dat0_in;

    assign accept     = cmd_valid & cmd_ready;
    assign is_long    = (rt_q == 2'b10);
    assign rx_len     = is_long ? CNT_W'(136) : CNT_W'(48);
    assign n_bit      = cnt + 1'b1;  // 1-based number of the bit arriving on this rise
    assign rx_nx      = {rx_sr, cmd_in};
    // Long responses exclude the 8 header bits from the CRC; short responses
    // cover everything before the CRC field.
    assign crc_en     = is_long ? (n_bit >= CNT_W'(9) && n_bit <= CNT_W'(128))
                                : (n_bit <= CNT_W'(40));

    assign tx_end     = (state == S_TX)   & fall_stb & (cnt == CNT_W'(48));
    assign ncc_end    = (state == S_NCC)  & rise_stb & (cnt == CNT_W'(NCC_MIN - 1));
    assign wait_start = (state == S_WAIT) & rise_stb & ~cmd_in;
    assign wait_to    = (state == S_WAIT) & rise_stb & cmd_in & (cnt == CNT_W'(NCR_MAX - 1));
    assign rx_last    = (state == S_RX)   & rise_stb & (cnt == rx_len - 1'b1);
    assign busy_end   = (state == S_BUSY) & rise_stb & (cnt == CNT_W'(2)) & dat0_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = S_TX;
            S_TX:   if (tx_end) state_nx = (rt_q == 2'b00) ? S_NCC : S_WAIT;
            S_NCC:  if (ncc_end) state_nx = S_DONE;
            S_WAIT: if (wait_start) state_nx = S_RX;
                    else if (wait_to) state_nx = S_DONE;
            S_RX:   if (rx_last) state_nx = (rt_q == 2'b11) ? S_BUSY : S_DONE;
            S_BUSY: if (busy_end) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_en       <= 1'b0;
            cnt          <= '0;
            tx_sr        <= '1;
            rx_sr        <= '0;
            rx_crc       <= '0;
            rt_q         <= '0;
            nocrc_q      <= 1'b0;
            cmd_out      <= 1'b1;
            cmd_oe       <= 1'b0;
            resp_data    <= '0;
            resp_crc_err <= 1'b0;
            resp_timeout <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            case (state)
                S_IDLE: if (accept) begin
                    cnt          <= '0;
                    tx_sr        <= {2'b01, cmd_index, cmd_arg,
                                     crc7_40({2'b01, cmd_index, cmd_arg}), 1'b1};
                    rx_sr        <= '0;
                    rx_crc       <= '0;
                    rt_q         <= resp_type;
                    nocrc_q      <= resp_nocrc;
                    resp_data    <= '0;
                    resp_crc_err <= 1'b0;
                    resp_timeout <= 1'b0;
                end
                S_TX: if (fall_stb) begin
                    if (cnt == CNT_W'(48)) begin
                        cmd_oe  <= 1'b0;
                        cmd_out <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cmd_oe  <= 1'b1;
                        cmd_out <= tx_sr[47];
                        tx_sr   <= {tx_sr[46:0], 1'b1};
                        cnt     <= cnt + 1'b1;
                    end
                end
                S_NCC: if (rise_stb) cnt <= cnt + 1'b1;
                S_WAIT: if (rise_stb) begin
                    // rx_sr is already zero, which stands in for the start bit;
                    // a leading zero also leaves a zero-init CRC unchanged.
                    if (!cmd_in)      cnt <= CNT_W'(1);
                    else if (wait_to) resp_timeout <= 1'b1;
                    else              cnt <= cnt + 1'b1;
                end
                S_RX: if (rise_stb) begin
                    rx_sr <= rx_nx[126:0];
                    cnt   <= cnt + 1'b1;
                    if (crc_en) rx_crc <= crc7_step(rx_crc, cmd_in);
                    if (rx_last) begin
                        cnt          <= '0;
                        resp_data    <= rx_nx;
                        resp_crc_err <= ((rx_crc != rx_nx[7:1]) & ~nocrc_q) | ~cmd_in;
                    end
                end
                S_BUSY: if (rise_stb && cnt != CNT_W'(2)) cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mmc_cmd_phy.sv
module tb_mmc_cmd_phy;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   clk_div = 8'd3;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [5:0]   cmd_index = '0;
    logic [31:0]  cmd_arg = '0;
    logic [1:0]   resp_type = '0;
    logic         resp_nocrc = 1'b0;
    logic         resp_valid;
    logic [127:0] resp_data;
    logic         resp_crc_err, resp_timeout, busy;
    logic         mmc_clk, cmd_out, cmd_oe;
    logic         cmd_in = 1'b1;
    logic         dat0_in = 1'b1;

    mmc_cmd_phy #(.DIV_W(8), .NCR_MAX(64), .NCC_MIN(8)) dut (
        .clk(clk), .reset(reset), .clk_div(clk_div),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg),
        .resp_type(resp_type), .resp_nocrc(resp_nocrc),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_crc_err(resp_crc_err), .resp_timeout(resp_timeout),
        .busy(busy), .mmc_clk(mmc_clk), .cmd_out(cmd_out), .cmd_oe(cmd_oe),
        .cmd_in(cmd_in), .dat0_in(dat0_in)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic mprev = 1'b0;
    logic rise, fall;

    // results of the last xfer
    logic [47:0]  tx_frame;
    int           tx_n, rise_after, busy_bad;
    logic         got_valid, v_crc, v_to, valid_early, valid_1clk, rdy_acc;
    logic [127:0] v_data;

    task automatic step();
        @(posedge clk);
        #1;
        rise  = mmc_clk & ~mprev;
        fall  = ~mmc_clk & mprev;
        mprev = mmc_clk;
    endtask

    // Issues one command and plays the card: optionally returns a response
    // (rdly falls after the command ends, -1 for none) and holds DAT0 low for
    // blen mmc clocks after the response.
    task automatic xfer(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                        input logic nc, input logic [135:0] resp, input int rlen,
                        input int rdly, input int blen);
        logic oe_prev, tx_done;
        int f, k;
        tx_frame = '0; tx_n = 0; rise_after = 0; busy_bad = 0;
        got_valid = 0; v_crc = 0; v_to = 0; v_data = '0; valid_early = 0; valid_1clk = 0;
        oe_prev = 0; tx_done = 0; f = 0;
        cmd_index = idx; cmd_arg = arg; resp_type = rt; resp_nocrc = nc; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        rdy_acc = cmd_ready;
        for (int c = 0; c < 4000 && !got_valid; c++) begin
            step();
            if (rise && cmd_oe) begin
                tx_frame = {tx_frame[46:0], cmd_out};
                tx_n++;
            end
            if (tx_done && rise) rise_after++;
            if (resp_valid) begin
                got_valid = 1;
                v_crc = resp_crc_err; v_to = resp_timeout; v_data = resp_data;
                if (blen > 0 && !dat0_in) valid_early = 1;
            end
            if (blen > 0 && tx_done) begin
                k = f - rdly;
                if (!dat0_in && k >= rlen) begin
                    if (busy !== 1'b1 || resp_valid !== 1'b0) busy_bad++;
                end else if (dat0_in || k < rlen - 1) begin
                    if (busy !== 1'b0) busy_bad++;
                end
            end
            if (fall && tx_done && rdly >= 0) begin
                f++;
                k = f - rdly;
                if (k >= 0 && k < rlen) cmd_in = resp[rlen-1-k];
                else if (k == rlen)     cmd_in = 1'b1;
                if (blen > 0 && k == 0)           dat0_in = 1'b0;
                if (blen > 0 && k == rlen + blen) dat0_in = 1'b1;
            end
            if (oe_prev && !cmd_oe) tx_done = 1;
            oe_prev = cmd_oe;
        end
        if (got_valid) begin
            step();
            valid_1clk = (resp_valid === 1'b0);
        end
        cmd_in = 1'b1;
        dat0_in = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) step();
        n_vec++;
        if ({mmc_clk, cmd_out, cmd_oe, cmd_ready, resp_valid, resp_crc_err, resp_timeout, busy} !== 8'b0100_0000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected 01000000",
                     {mmc_clk, cmd_out, cmd_oe, cmd_ready, resp_valid, resp_crc_err, resp_timeout, busy});
        end
        n_vec++;
        if (resp_data !== 128'h0) begin
            n_bad++; $display("FAIL reset_data: got %h expected 0", resp_data);
        end
        reset = 1'b0;
        n_vec++;
        if (cmd_ready !== 1'b0) begin
            n_bad++; $display("FAIL ready_at_release: got %b expected 0", cmd_ready);
        end
        step();
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL ready_after_1clk: got %b expected 1", cmd_ready);
        end
    endtask

    // Continues from the first clk after reset release with clk_div=3.
    task automatic test_divider();
        int edges, hi, lo;
        edges = 1;
        while (mmc_clk == 1'b0 && edges < 20) begin step(); edges++; end
        n_vec++;
        if (edges != 4) begin
            n_bad++; $display("FAIL first_rise: got %0d clk expected 4", edges);
        end
        hi = 0;
        while (mmc_clk == 1'b1 && hi < 20) begin step(); hi++; end
        lo = 0;
        while (mmc_clk == 1'b0 && lo < 20) begin step(); lo++; end
        n_vec++;
        if (hi != 4 || lo != 4) begin
            n_bad++; $display("FAIL div_duty: got high %0d low %0d expected 4 4", hi, lo);
        end
        clk_div = 8'd0;
        repeat (10) step();
    endtask

    task automatic test_cmd0();
        xfer(6'd0, 32'h0, 2'b00, 1'b0, 136'h0, 48, -1, 0);
        n_vec++;
        if (rdy_acc !== 1'b0) begin
            n_bad++; $display("FAIL cmd0_ready_drop: got %b expected 0", rdy_acc);
        end
        n_vec++;
        if (tx_frame !== 48'h400000000095 || tx_n != 48) begin
            n_bad++; $display("FAIL cmd0_frame: got %h/%0d bits expected 400000000095/48", tx_frame, tx_n);
        end
        n_vec++;
        if (!got_valid || rise_after != 8) begin
            n_bad++; $display("FAIL cmd0_ncc: got valid %b after %0d rises expected 1 after 8", got_valid, rise_after);
        end
        n_vec++;
        if ({v_crc, v_to} !== 2'b00 || !valid_1clk) begin
            n_bad++; $display("FAIL cmd0_flags: got crc %b to %b single %b expected 0 0 1", v_crc, v_to, valid_1clk);
        end
    endtask

    task automatic test_cmd8_timeout();
        xfer(6'd8, 32'h1AA, 2'b01, 1'b0, 136'h0, 48, -1, 0);
        n_vec++;
        if (tx_frame !== 48'h48000001AA87 || tx_n != 48) begin
            n_bad++; $display("FAIL cmd8_frame: got %h/%0d bits expected 48000001aa87/48", tx_frame, tx_n);
        end
        n_vec++;
        if (!got_valid || rise_after != 64) begin
            n_bad++; $display("FAIL cmd8_timeout_at: got valid %b after %0d rises expected 1 after 64", got_valid, rise_after);
        end
        n_vec++;
        if (v_to !== 1'b1 || v_crc !== 1'b0 || v_data !== 128'h0) begin
            n_bad++; $display("FAIL cmd8_flags: got to %b crc %b data %h expected 1 0 0", v_to, v_crc, v_data);
        end
    endtask

    task automatic test_short_resp();
        logic [47:0] rs [4];
        logic        nc [4];
        logic        ce [4];
        rs[0] = 48'h400000000095; nc[0] = 0; ce[0] = 0;  // clean
        rs[1] = 48'h400000100095; nc[1] = 0; ce[1] = 1;  // bit 20 flipped
        rs[2] = 48'h400000100095; nc[2] = 1; ce[2] = 0;  // flipped, CRC ignored
        rs[3] = 48'h400000000094; nc[3] = 0; ce[3] = 1;  // end bit 0
        for (int i = 0; i < 4; i++) begin
            xfer(6'd17, 32'h0, 2'b01, nc[i], {88'h0, rs[i]}, 48, 2, 0);
            n_vec++;
            if (!got_valid || v_to !== 1'b0 || v_crc !== ce[i]) begin
                n_bad++; $display("FAIL short_flags[%0d]: got valid %b to %b crc %b expected 1 0 %b",
                                  i, got_valid, v_to, v_crc, ce[i]);
            end
            n_vec++;
            if (v_data !== {80'h0, rs[i]}) begin
                n_bad++; $display("FAIL short_data[%0d]: got %h expected %h", i, v_data, {80'h0, rs[i]});
            end
        end
    endtask

    // Runs right after a failing response: flags and data must clear on accept.
    task automatic test_back_to_back();
        xfer(6'd0, 32'h0, 2'b00, 1'b0, 136'h0, 48, -1, 0);
        n_vec++;
        if (!got_valid || v_crc !== 1'b0 || v_to !== 1'b0 || v_data !== 128'h0) begin
            n_bad++; $display("FAIL clear_on_accept: got valid %b crc %b to %b data %h expected 1 0 0 0",
                              got_valid, v_crc, v_to, v_data);
        end
    endtask

    task automatic test_long_resp();
        logic [127:0] ld [3];
        logic         nc [3];
        logic         ce [3];
        ld[0] = 128'h1;                                 nc[0] = 0; ce[0] = 0;
        ld[1] = 128'h3;                                 nc[1] = 0; ce[1] = 1;
        ld[2] = 128'h0123456789ABCDEF_FEDCBA9876543211; nc[2] = 1; ce[2] = 0;
        for (int i = 0; i < 3; i++) begin
            xfer(6'd2, 32'h0, 2'b10, nc[i], {8'h3F, ld[i]}, 136, 2, 0);
            n_vec++;
            if (!got_valid || v_to !== 1'b0 || v_crc !== ce[i]) begin
                n_bad++; $display("FAIL long_flags[%0d]: got valid %b to %b crc %b expected 1 0 %b",
                                  i, got_valid, v_to, v_crc, ce[i]);
            end
            n_vec++;
            if (v_data !== ld[i]) begin
                n_bad++; $display("FAIL long_data[%0d]: got %h expected %h", i, v_data, ld[i]);
            end
        end
    endtask

    task automatic test_busy();
        xfer(6'd12, 32'h0, 2'b11, 1'b0, {88'h0, 48'h400000000095}, 48, 2, 100);
        n_vec++;
        if (busy_bad != 0) begin
            n_bad++; $display("FAIL busy_level: got %0d bad cycles expected 0", busy_bad);
        end
        n_vec++;
        if (!got_valid || valid_early) begin
            n_bad++; $display("FAIL busy_done: got valid %b early %b expected 1 0", got_valid, valid_early);
        end
        n_vec++;
        if (v_crc !== 1'b0 || v_data !== {80'h0, 48'h400000000095}) begin
            n_bad++; $display("FAIL busy_resp: got crc %b data %h expected 0 400000000095", v_crc, v_data);
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [19:0] frame20;
        int bits, rdy_bad;
        cmd_index = 6'd0; cmd_arg = 32'h0; resp_type = 2'b00; resp_nocrc = 1'b0;
        cmd_valid = 1'b1;
        step();
        cmd_index = 6'd5;  // cmd_valid stays high: must be ignored mid-transfer
        bits = 0; rdy_bad = 0; frame20 = '0;
        for (int c = 0; c < 500 && bits < 20; c++) begin
            step();
            if (cmd_ready !== 1'b0) rdy_bad++;
            if (rise && cmd_oe) begin
                frame20 = {frame20[18:0], cmd_out};
                bits++;
            end
        end
        n_vec++;
        if (bits != 20 || frame20 !== 20'h40000 || rdy_bad != 0) begin
            n_bad++; $display("FAIL midtx_prefix: got %h/%0d bits ready-high %0d expected 40000/20 0",
                              frame20, bits, rdy_bad);
        end
        cmd_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if ({cmd_oe, cmd_out, mmc_clk} !== 3'b010) begin
            n_bad++; $display("FAIL async_reset_pads: got oe %b out %b clk %b expected 0 1 0",
                              cmd_oe, cmd_out, mmc_clk);
        end
        step(); step();
        reset = 1'b0;
        mprev = mmc_clk;
        step();
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL ready_after_rerelease: got %b expected 1", cmd_ready);
        end
        xfer(6'd0, 32'h0, 2'b00, 1'b0, 136'h0, 48, -1, 0);
        n_vec++;
        if (tx_frame !== 48'h400000000095 || tx_n != 48 || !got_valid || rise_after != 8) begin
            n_bad++; $display("FAIL cmd0_after_reset: got %h/%0d valid %b after %0d expected 400000000095/48 1 after 8",
                              tx_frame, tx_n, got_valid, rise_after);
        end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_cmd0();
        test_cmd8_timeout();
        test_short_resp();
        test_back_to_back();
        test_long_resp();
        test_busy();
        test_reset_mid_tx();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
